// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-way round-robin arbiter with a registered one-hot grant
// and a matching binary index. A grant is held until done, withdrawal, a
// hold-time limit or a global disable. On release the next winner is
// loaded at the same edge, so there is no idle cycle between grants.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  synchronous active-low reset
//   en         in   1  enable; 0 releases the current grant and blocks new ones
//   req        in   4  request lines, bit i = requester i
//   done       in   1  current owner finished (ignored while idle)
//   gnt        out  4  one-hot grant, zero when there is no owner
//   gnt_idx    out  2  binary index of the owner, zero when there is no owner
//   gnt_valid  out  1  a grant is held (OR of gnt)
//   timeout    out  1  one-cycle pulse after a release caused by the hold limit
module rr_arbiter_4 #(
   parameter int unsigned MAX_HOLD   = 8,
   parameter int unsigned PRIO_RESET = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   localparam int unsigned N  = 4;
   localparam int unsigned IW = 2;
   localparam int unsigned CW = 8;

   // Hold limit only applies when MAX_HOLD is non-zero; LIM_LAST is the
   // hold_cnt value of the final permitted grant cycle.
   localparam bit            LIM_ON   = (MAX_HOLD != 0);
   localparam logic [CW-1:0] LIM_LAST = CW'(MAX_HOLD - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t        r_state;
   logic [IW-1:0] r_ptr;
   logic [CW-1:0] r_hold_cnt;
   logic [N-1:0]  r_gnt;
   logic [IW-1:0] r_idx;
   logic          r_valid;
   logic          r_timeout;

   logic          w_rel_en;
   logic          w_rel_done;
   logic          w_rel_wd;
   logic          w_rel_lim;
   logic          w_release;
   logic [IW-1:0] w_scan_ptr;
   logic [N-1:0]  w_mask;
   logic          w_found;
   logic [IW-1:0] w_win;

   assign gnt       = r_gnt;
   assign gnt_idx   = r_idx;
   assign gnt_valid = r_valid;
   assign timeout   = r_timeout;

   // Release causes, each masked by the higher-priority ones so exactly one fires.
   assign w_rel_en   = ~en;
   assign w_rel_done = en & done;
   assign w_rel_wd   = en & ~done & ~req[r_idx];
   assign w_rel_lim  = en & ~done & req[r_idx] & LIM_ON & (r_hold_cnt == LIM_LAST);
   assign w_release  = (r_state == S_GRANT) &
                       (w_rel_en | w_rel_done | w_rel_wd | w_rel_lim);

   // While granting, the search starts just past the owner (the pointer value
   // that a release will store); while idle it starts at the stored pointer.
   assign w_scan_ptr = (r_state == S_GRANT) ? IW'(r_idx + IW'(1)) : r_ptr;

   // A withdrawing owner is excluded from the re-evaluation.
   always_comb begin
      w_mask = req;
      if (w_rel_wd) begin
         w_mask[r_idx] = 1'b0;
      end
   end

   // First set bit of w_mask at or after w_scan_ptr, wrapping mod 4.
   // Scanned from the far end so the nearest candidate is the last to assign.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_mask[IW'(w_scan_ptr + IW'(k))]) begin
            w_found = 1'b1;
            w_win   = IW'(w_scan_ptr + IW'(k));
         end
      end
   end

   // Arbiter state machine with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_ptr      <= IW'(PRIO_RESET);
         r_hold_cnt <= '0;
         r_gnt      <= '0;
         r_idx      <= '0;
         r_valid    <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (en && w_found) begin
                  r_state    <= S_GRANT;
                  r_gnt      <= N'(1) << w_win;
                  r_idx      <= w_win;
                  r_valid    <= 1'b1;
                  r_hold_cnt <= '0;
               end
            end
            S_GRANT: begin
               if (!w_release) begin
                  if (r_hold_cnt != CNT_MAX) begin
                     r_hold_cnt <= r_hold_cnt + CW'(1);
                  end
               end else begin
                  r_ptr      <= w_scan_ptr;
                  r_timeout  <= w_rel_lim;
                  r_hold_cnt <= '0;
                  if (en && w_found) begin
                     r_gnt   <= N'(1) << w_win;
                     r_idx   <= w_win;
                     r_valid <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     r_gnt   <= '0;
                     r_idx   <= '0;
                     r_valid <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_gnt   <= '0;
               r_idx   <= '0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Testbench for rr_arbiter_4: a cycle model pushes expected outputs into a
// scoreboard queue as each cycle's stimulus is applied; the queue is popped
// and compared one time unit after the clock edge. Directed scenarios add
// constant expectations on top of the scoreboard.
module tb_rr_arbiter_4;

   localparam int unsigned TB_MAX_HOLD   = 8;
   localparam int unsigned TB_PRIO_RESET = 0;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   int n_chk  = 0;
   int n_pass = 0;

   // Model state
   logic       m_valid;
   logic [1:0] m_idx;
   logic [1:0] m_ptr;
   int         m_hold;
   logic       m_to;
   logic [3:0] m_gnt;

   logic [7:0] sb_q[$];

   rr_arbiter_4 #(
      .MAX_HOLD  (TB_MAX_HOLD),
      .PRIO_RESET(TB_PRIO_RESET)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .req      (req),
      .done     (done),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx),
      .gnt_valid(gnt_valid),
      .timeout  (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Returns {found, index} of the first set bit of m starting at start.
   function automatic logic [2:0] pick(input logic [3:0] m, input logic [1:0] start);
      for (int k = 0; k < 4; k++) begin
         int j;
         j = (int'(start) + k) % 4;
         if (m[j]) return {1'b1, 2'(j)};
      end
      return 3'b000;
   endfunction

   task automatic model_update(input logic [3:0] r, input logic e, input logic d, input logic rn);
      int         cause;
      logic [3:0] msk;
      logic [2:0] p;
      if (!rn) begin
         m_valid = 1'b0; m_idx = 2'd0; m_ptr = 2'(TB_PRIO_RESET); m_hold = 0; m_to = 1'b0;
      end else if (!m_valid) begin
         m_to = 1'b0;
         p = pick(r, m_ptr);
         if (e && p[2]) begin
            m_valid = 1'b1; m_idx = p[1:0]; m_hold = 0;
         end
      end else begin
         if (!e)                                                   cause = 1;
         else if (d)                                               cause = 2;
         else if (!r[m_idx])                                       cause = 3;
         else if (TB_MAX_HOLD != 0 && m_hold == TB_MAX_HOLD - 1)   cause = 4;
         else                                                      cause = 0;
         if (cause == 0) begin
            m_to = 1'b0;
            if (m_hold < 255) m_hold = m_hold + 1;
         end else begin
            m_to  = (cause == 4);
            m_ptr = 2'((int'(m_idx) + 1) % 4);
            msk   = r;
            if (cause == 3) msk[m_idx] = 1'b0;
            p = pick(msk, m_ptr);
            m_hold = 0;
            if (e && p[2]) begin
               m_idx = p[1:0];
            end else begin
               m_valid = 1'b0; m_idx = 2'd0;
            end
         end
      end
      m_gnt = m_valid ? (4'b0001 << m_idx) : 4'b0000;
   endtask

   // Apply one cycle of stimulus, queue the expectation, then compare.
   task automatic step(input logic [3:0] r, input logic e, input logic d, input logic rn);
      logic [7:0] exp;
      req = r; en = e; done = d; rst_n = rn;
      model_update(r, e, d, rn);
      sb_q.push_back({m_gnt, m_idx, m_valid, m_to});
      @(posedge clk);
      #1;
      exp = sb_q.pop_front();
      check_eq("sb", 32'({gnt, gnt_idx, gnt_valid, timeout}), 32'(exp));
      check_eq("onehot0", 32'($onehot0(gnt)), 32'd1);
   endtask

   initial begin
      int exp_seq[6];
      int nto;
      logic [3:0] r;
      logic       e, d, rn;
      exp_seq = '{0, 1, 2, 3, 0, 1};
      rst_n = 1'b0; en = 1'b0; req = 4'b0; done = 1'b0;
      m_valid = 1'b0; m_idx = 2'd0; m_ptr = 2'd0; m_hold = 0; m_to = 1'b0; m_gnt = 4'b0;

      // Reset state
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      step(4'b1111, 1'b1, 1'b0, 1'b0);
      check_eq("rst_gnt", 32'(gnt), 32'd0);
      check_eq("rst_valid", 32'(gnt_valid), 32'd0);

      // Done hands over to the next requester without a bubble
      step(4'b0101, 1'b1, 1'b0, 1'b1);
      check_eq("t1_gnt0", 32'(gnt), 32'b0001);
      check_eq("t1_idx0", 32'(gnt_idx), 32'd0);
      step(4'b0101, 1'b1, 1'b1, 1'b1);
      check_eq("t1_gnt2", 32'(gnt), 32'b0100);
      check_eq("t1_idx2", 32'(gnt_idx), 32'd2);

      // Full rotation with done every cycle
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step(4'b1111, 1'b1, 1'b1, 1'b1);
         check_eq("rr_seq", 32'(gnt_idx), 32'(exp_seq[i]));
         check_eq("rr_valid", 32'(gnt_valid), 32'd1);
      end

      // Hold limit with a single requester: re-grant plus periodic timeout
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      step(4'b0010, 1'b1, 1'b0, 1'b1);
      nto = 0;
      for (int i = 0; i < 24; i++) begin
         step(4'b0010, 1'b1, 1'b0, 1'b1);
         check_eq("lim_gnt", 32'(gnt), 32'b0010);
         if (timeout) nto++;
         if (i == 7 || i == 15 || i == 23) check_eq("lim_to", 32'(timeout), 32'd1);
      end
      check_eq("lim_to_cnt", 32'(nto), 32'd3);

      // Withdrawal with no other requester, then pointer past the old owner
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      step(4'b1000, 1'b1, 1'b0, 1'b1);
      check_eq("wd_idx3", 32'(gnt_idx), 32'd3);
      step(4'b0000, 1'b1, 1'b0, 1'b1);
      check_eq("wd_gnt", 32'(gnt), 32'd0);
      check_eq("wd_to", 32'(timeout), 32'd0);
      step(4'b0001, 1'b1, 1'b0, 1'b1);
      check_eq("wd_next", 32'(gnt), 32'b0001);

      // done on the final permitted cycle wins over the limit
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(4'b0001, 1'b1, 1'b0, 1'b1);
      step(4'b0001, 1'b1, 1'b1, 1'b1);
      check_eq("done_lim_to", 32'(timeout), 32'd0);
      check_eq("done_lim_gnt", 32'(gnt), 32'b0001);
      // Disable mid-grant, and no grant while disabled
      step(4'b0001, 1'b0, 1'b0, 1'b1);
      check_eq("en0_gnt", 32'(gnt), 32'd0);
      step(4'b0001, 1'b0, 1'b0, 1'b1);
      check_eq("en0_hold", 32'(gnt_valid), 32'd0);
      step(4'b0001, 1'b1, 1'b0, 1'b1);
      check_eq("en1_gnt", 32'(gnt), 32'b0001);

      // Reset mid-grant restores the reset priority
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      step(4'b0100, 1'b1, 1'b0, 1'b1);
      check_eq("rg_idx2", 32'(gnt_idx), 32'd2);
      step(4'b1111, 1'b1, 1'b0, 1'b0);
      check_eq("rg_gnt", 32'(gnt), 32'd0);
      check_eq("rg_to", 32'(timeout), 32'd0);
      step(4'b1111, 1'b1, 1'b0, 1'b1);
      check_eq("rg_prio", 32'(gnt_idx), 32'(TB_PRIO_RESET));

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         r  = 4'($urandom);
         e  = ($urandom_range(0, 11) != 0);
         d  = ($urandom_range(0, 7) == 0);
         rn = ($urandom_range(0, 79) != 0);
         step(r, e, d, rn);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Round-robin arbiter that shares one 2-bit encoded index path among four requesters.
- Produces a registered one-hot grant and its matching binary index (requester i -> index i), so downstream logic sees a clean one-hot/binary pair every cycle.
- Sits in front of the 4:2 encoding datapath.
- Supports grant hold until `done`, requester withdrawal, a hold-time limit, and a global enable.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles per winner. Range 0..255; 0 disables the limit.
- PRIO_RESET, 0: requester index (0..3) the round-robin pointer takes at reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset is synchronous and active-low.
- en  input  1  arbiter enable; 0 forces release and blocks new grants.
- req  input  4  request lines; bit i = requester i.
- done  input  1  current owner finished; sampled only while gnt_valid=1.
- gnt  output  4  one-hot grant; all-zero when no owner.
- gnt_idx  output  2  binary index of owner; 0 when gnt_valid=0.
- gnt_valid  output  1  1 while a grant is held; equals OR of gnt.
- timeout  output  1  one-cycle pulse when a grant is released by MAX_HOLD.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0.
  - Internal: ptr=PRIO_RESET, hold_cnt=0, state IDLE.
  - Reset mid-grant drops the grant at that edge; no timeout pulse.
- States: IDLE, GRANT. All outputs are registered.
- Winner selection: first set bit of req scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE:
  - If en=1 and req!=0: next edge loads gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, hold_cnt=0, state GRANT.
  - Latency from req assertion to gnt is 1 cycle.
  - Otherwise remain IDLE with outputs zero.
- GRANT: each cycle, evaluate release conditions in this priority order:
  1. en=0
  2. done=1
  3. req[gnt_idx]=0 (withdrawal)
  4. MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 (limit)
- No release: hold_cnt increments (saturates at 255); outputs unchanged.
- On release, at the same edge:
  - ptr <= gnt_idx+1 (mod 4).
  - Winner is re-evaluated from the new ptr using current req, with the releasing requester excluded if it withdrew.
  - If en=1 and a winner exists: new grant loads immediately, no bubble cycle, hold_cnt=0, stay GRANT.
  - Otherwise: outputs clear, state IDLE.
- timeout:
  - Asserted for exactly one cycle (the cycle after the release edge) only when the release cause is the limit.
  - Not asserted if done=1, withdrawal, or en=0 occurs in the same cycle; higher-priority causes win.
  - Asserted even if the same requester is re-granted, i.e. it was the only requester. In that case gnt stays constant and hold_cnt restarts.
- Ignored inputs: done while IDLE; req changes of non-owners while in GRANT.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_idx always matches gnt.
  - No requester with a continuously asserted req waits more than 3 grant periods.

Test Plan:
- Reset, then req=0101, ptr=0 -> cycle 1: gnt=0001, gnt_idx=0. Assert done for 1 cycle -> next edge gnt=0100, gnt_idx=2 with no idle cycle.
- req=1111 held, done pulsed every grant cycle -> grant index sequence 0,1,2,3,0,1; gnt_valid stays 1 throughout.
- MAX_HOLD=8, req=0010 only, done=0 -> gnt=0010 for 8 cycles, timeout=1 for one cycle after cycle 8, gnt stays 0010 (re-grant), timeout repeats every 8 cycles.
- Granted to 3, drop req[3] with req=0000 -> next edge gnt=0000, gnt_valid=0, timeout=0. Then req=0001 -> grant index 0 (ptr=0).
- Grant held at hold_cnt=MAX_HOLD-1 with done=1 same cycle -> release, timeout stays 0. Separately, en=0 mid-grant -> gnt=0000 next edge, no new grant until en=1.
- Granted to 2, pull rst_n=0 for one edge with req=1111 -> all outputs 0. After rst_n=1, next grant is PRIO_RESET (0), not 3.
